// File: rtl/mips_pkg.sv
// Shared definitions for the register bank: default widths and the
// dump sequencer state encoding.
package mips_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 5;

  typedef logic [1:0] dump_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/reg_bank_if.sv
// Bus interface of the register bank: two read ports, one write-back port
// and the register dump stream.
//
// Dump handshake (valid/ready): a beat transfers on a rising edge where
// o_dump_valid && i_dump_ready. While o_dump_valid=1 and i_dump_ready=0 the
// payload (o_dump_data, o_dump_addr) is held unchanged. o_dump_valid never
// drops without a transfer, except on reset.
interface reg_bank_if
  import mips_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
);

  logic [NB_ADDR-1:0] i_rs_addr;
  logic [NB_ADDR-1:0] i_rt_addr;
  logic [NB_DATA-1:0] o_rs_data;
  logic [NB_DATA-1:0] o_rt_data;
  logic [NB_DATA-1:0] i_write_data;
  logic [NB_ADDR-1:0] i_reg2write;
  logic               i_regWrite;
  logic               i_dump_start;
  logic               o_dump_valid;
  logic               i_dump_ready;
  logic [NB_DATA-1:0] o_dump_data;
  logic [NB_ADDR-1:0] o_dump_addr;
  logic               o_dump_busy;
  logic               o_dump_done;
  dump_state_t        o_dump_state;  // debug view of the dump FSM

  modport slave (
    input  i_rs_addr, i_rt_addr, i_write_data, i_reg2write, i_regWrite,
    input  i_dump_start, i_dump_ready,
    output o_rs_data, o_rt_data,
    output o_dump_valid, o_dump_data, o_dump_addr, o_dump_busy, o_dump_done,
    output o_dump_state
  );

  modport master (
    output i_rs_addr, i_rt_addr, i_write_data, i_reg2write, i_regWrite,
    output i_dump_start, i_dump_ready,
    input  o_rs_data, o_rt_data,
    input  o_dump_valid, o_dump_data, o_dump_addr, o_dump_busy, o_dump_done,
    input  o_dump_state
  );

endinterface

// File: rtl/reg_bank_dump.sv
// Register dump sequencer: walks indices 0..2**NB_ADDR-1, presenting one
// beat per index on a valid/ready stream, then pulses done for one cycle.
// The payload is a snapshot taken when the beat is loaded, so later writes
// to that register do not disturb a stalled beat.
module reg_bank_dump
  import mips_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_ready,
  input  logic [NB_DATA-1:0] i_rd_data,  // storage contents at o_rd_addr
  output logic [NB_ADDR-1:0] o_rd_addr,  // index of the beat to load next
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_ADDR-1:0] o_addr,
  output dump_state_t        o_state
);

  localparam logic [NB_ADDR-1:0] LAST_IDX = {NB_ADDR{1'b1}};

  dump_state_t        state;
  logic [NB_ADDR-1:0] index;
  logic [NB_DATA-1:0] data_q;

  // Next index to fetch: 0 when starting, index+1 when advancing.
  always_comb begin
    o_rd_addr = '0;
    if (state == ST_SEND) o_rd_addr = index + NB_ADDR'(1);
  end

  // FSM, index counter and payload snapshot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      index  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_SEND;
            index  <= '0;
            data_q <= i_rd_data;
          end
        end
        ST_SEND: begin
          if (i_ready) begin
            if (index == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              index  <= index + NB_ADDR'(1);
              data_q <= i_rd_data;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid = (state == ST_SEND);
  assign o_busy  = (state == ST_SEND);
  assign o_done  = (state == ST_DONE);
  assign o_data  = data_q;
  assign o_addr  = index;
  assign o_state = state;

endmodule

// File: rtl/reg_bank.sv
// Register bank: 2**NB_ADDR registers, register 0 hard-wired to zero,
// two combinational read ports, one write-back port and a dump stream.
// Optional macro REG_BANK_BYPASS_EN: a read of the register being written
// in the same cycle returns the incoming write data instead of the old value.
module reg_bank
  import mips_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input logic      i_clk,
  input logic      i_rst,
  reg_bank_if.slave bus
);

  localparam int NUM_REGS = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] regs [NUM_REGS];
  logic               wr_en;
  logic [NB_DATA-1:0] rs_data;
  logic [NB_DATA-1:0] rt_data;
  logic [NB_ADDR-1:0] dump_rd_addr;
  logic [NB_DATA-1:0] dump_rd_data;

  assign wr_en = bus.i_regWrite && (bus.i_reg2write != '0);

  // Register storage: cleared by reset, written from the write-back stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.i_reg2write] <= bus.i_write_data;
    end
  end

  // Read port rs, zero latency.
  always_comb begin
    rs_data = (bus.i_rs_addr == '0) ? '0 : regs[bus.i_rs_addr];
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && (bus.i_rs_addr == bus.i_reg2write)) rs_data = bus.i_write_data;
`endif
  end

  // Read port rt, zero latency.
  always_comb begin
    rt_data = (bus.i_rt_addr == '0) ? '0 : regs[bus.i_rt_addr];
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && (bus.i_rt_addr == bus.i_reg2write)) rt_data = bus.i_write_data;
`endif
  end

  assign bus.o_rs_data = rs_data;
  assign bus.o_rt_data = rt_data;

  // The dump sees stored contents only (never the bypass path), so a beat
  // captures the value before the write on the same edge.
  assign dump_rd_data = (dump_rd_addr == '0) ? '0 : regs[dump_rd_addr];

  reg_bank_dump #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) u_dump (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (bus.i_dump_start),
    .i_ready  (bus.i_dump_ready),
    .i_rd_data(dump_rd_data),
    .o_rd_addr(dump_rd_addr),
    .o_valid  (bus.o_dump_valid),
    .o_busy   (bus.o_dump_busy),
    .o_done   (bus.o_dump_done),
    .o_data   (bus.o_dump_data),
    .o_addr   (bus.o_dump_addr),
    .o_state  (bus.o_dump_state)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Testbench for reg_bank: table-driven read/write vectors plus directed
// dump sequences (free-running, stalled with a concurrent write, reset mid-dump).
module tb_reg_bank;
  import mips_pkg::*;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int NREG = 32;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [NB_DATA-1:0]          mem [NREG];
  logic [NB_ADDR+NB_DATA-1:0]  exp_q [$];

  reg_bank_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

  reg_bank #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic               we;
    logic [NB_ADDR-1:0] wa;
    logic [NB_DATA-1:0] wd;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_DATA-1:0] exp_rs;
    logic [NB_DATA-1:0] exp_rt;
  } vec_t;

  vec_t vecs [10];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [NB_DATA-1:0] act,
                       input logic [NB_DATA-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input int a, input logic [NB_DATA-1:0] d);
    bus.i_regWrite   = 1'b1;
    bus.i_reg2write  = NB_ADDR'(a);
    bus.i_write_data = d;
    tick();
    bus.i_regWrite   = 1'b0;
    if (a != 0) mem[a] = d;
  endtask

  initial begin
    bus.i_rs_addr    = '0;
    bus.i_rt_addr    = '0;
    bus.i_write_data = '0;
    bus.i_reg2write  = '0;
    bus.i_regWrite   = 1'b0;
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;
    for (int i = 0; i < NREG; i++) mem[i] = '0;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'd0, 32'd0};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0,  32'hDEADBEEF, 32'd0};
    vecs[2] = '{1'b0, 5'd0,  32'd0,        5'd0,  5'd5,  32'd0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd5,  5'd7,  32'hDEADBEEF,
                (BYP ? 32'hA5A5A5A5 : 32'd0)};
    vecs[4] = '{1'b0, 5'd0,  32'd0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30,
                (BYP ? 32'h80000001 : 32'd0), 32'd0};
    vecs[6] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd31,
                (BYP ? 32'h11111111 : 32'hDEADBEEF), 32'h80000001};
    vecs[7] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd7,  32'h11111111, 32'hA5A5A5A5};
    vecs[8] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'd0, 32'd0};
    vecs[9] = '{1'b0, 5'd0,  32'd0,        5'd0,  5'd5,  32'd0, 32'h11111111};

    // reset state
    #12;
    check("rst_valid", 32'(bus.o_dump_valid), 32'd0);
    check("rst_busy",  32'(bus.o_dump_busy),  32'd0);
    check("rst_done",  32'(bus.o_dump_done),  32'd0);
    check("rst_data",  bus.o_dump_data,       32'd0);
    check("rst_state", 32'(bus.o_dump_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      bus.i_rs_addr = NB_ADDR'(i);
      #1;
      check($sformatf("rst_reg%0d", i), bus.o_rs_data, 32'd0);
    end
    tick();

    // table-driven read/write vectors
    for (int v = 0; v < 10; v++) begin
      bus.i_regWrite   = vecs[v].we;
      bus.i_reg2write  = vecs[v].wa;
      bus.i_write_data = vecs[v].wd;
      bus.i_rs_addr    = vecs[v].rs;
      bus.i_rt_addr    = vecs[v].rt;
      #1;
      check($sformatf("vec%0d_rs", v), bus.o_rs_data, vecs[v].exp_rs);
      check($sformatf("vec%0d_rt", v), bus.o_rt_data, vecs[v].exp_rt);
      tick();
    end
    bus.i_regWrite = 1'b0;

    // dump with ready held high: fill rN = N*3
    for (int n = 1; n < NREG; n++) write_reg(n, 32'(n * 3));
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b1;
    tick();
    // start stays high through the dump; it must be ignored in SEND/DONE
    for (int b = 0; b < NREG; b++) begin
      #1;
      check($sformatf("runA_valid%0d", b), 32'(bus.o_dump_valid), 32'd1);
      check($sformatf("runA_busy%0d", b),  32'(bus.o_dump_busy),  32'd1);
      check($sformatf("runA_addr%0d", b),  32'(bus.o_dump_addr),  32'(b));
      check($sformatf("runA_data%0d", b),  bus.o_dump_data,       mem[b]);
      tick();
    end
    check("runA_done",  32'(bus.o_dump_done),  32'd1);
    check("runA_dvalid", 32'(bus.o_dump_valid), 32'd0);
    check("runA_dbusy", 32'(bus.o_dump_busy),  32'd0);
    check("runA_state", 32'(bus.o_dump_state), 32'(ST_DONE));
    bus.i_dump_start = 1'b0;
    tick();
    check("runA_done_off", 32'(bus.o_dump_done),  32'd0);
    check("runA_idle",     32'(bus.o_dump_valid), 32'd0);

    // dump with ready toggling, write to r3 while beat 3 is stalled
    for (int b = 0; b < NREG; b++) exp_q.push_back({NB_ADDR'(b), mem[b]});
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b0;
    tick();
    bus.i_dump_start = 1'b0;
    begin
      int beats = 0;
      int cyc = 0;
      logic [NB_ADDR+NB_DATA-1:0] e;
      while (beats < NREG && cyc < 200) begin
        bus.i_regWrite   = 1'b0;
        bus.i_dump_ready = cyc[0];
        if (beats == 3 && !cyc[0]) begin
          bus.i_regWrite   = 1'b1;
          bus.i_reg2write  = 5'd3;
          bus.i_write_data = 32'h0000FFFF;
          mem[3] = 32'h0000FFFF;
        end
        #1;
        e = exp_q[0];
        check($sformatf("runB_valid_c%0d", cyc), 32'(bus.o_dump_valid), 32'd1);
        check($sformatf("runB_addr_c%0d", cyc), 32'(bus.o_dump_addr),
              32'(e[NB_ADDR+NB_DATA-1:NB_DATA]));
        check($sformatf("runB_data_c%0d", cyc), bus.o_dump_data, e[NB_DATA-1:0]);
        if (bus.i_dump_ready) begin
          void'(exp_q.pop_front());
          beats++;
        end
        tick();
        cyc++;
      end
      bus.i_regWrite = 1'b0;
      check("runB_beats", 32'(beats), 32'(NREG));
    end
    check("runB_done", 32'(bus.o_dump_done), 32'd1);
    bus.i_dump_ready = 1'b0;
    tick();
    check("runB_done_off", 32'(bus.o_dump_done), 32'd0);
    bus.i_rs_addr = 5'd3;
    bus.i_rt_addr = 5'd4;
    #1;
    check("runB_r3", bus.o_rs_data, 32'h0000FFFF);
    check("runB_r4", bus.o_rt_data, 32'd12);

    // reset asserted during beat 10
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    for (int b = 0; b < 10; b++) tick();
    check("runC_addr10", 32'(bus.o_dump_addr), 32'd10);
    check("runC_data10", bus.o_dump_data, 32'd30);
    #1;
    rst = 1'b1;
    #1;
    check("runC_rst_valid", 32'(bus.o_dump_valid), 32'd0);
    check("runC_rst_busy",  32'(bus.o_dump_busy),  32'd0);
    check("runC_rst_done",  32'(bus.o_dump_done),  32'd0);
    check("runC_rst_data",  bus.o_dump_data,       32'd0);
    check("runC_rst_addr",  32'(bus.o_dump_addr),  32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) mem[i] = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("runC_nodone%0d", c), 32'(bus.o_dump_done), 32'd0);
    end
    for (int i = 0; i < NREG; i++) begin
      bus.i_rs_addr = NB_ADDR'(i);
      #1;
      check($sformatf("runC_reg%0d", i), bus.o_rs_data, 32'd0);
    end
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b0;
    tick();
    bus.i_dump_start = 1'b0;
    check("runC_re_valid", 32'(bus.o_dump_valid), 32'd1);
    check("runC_re_addr0", 32'(bus.o_dump_addr),  32'd0);
    check("runC_re_data0", bus.o_dump_data,       32'd0);
    bus.i_dump_ready = 1'b1;
    tick();
    check("runC_re_addr1", 32'(bus.o_dump_addr), 32'd1);
    check("runC_re_data1", bus.o_dump_data,      32'd0);
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        if (bus.o_dump_done) seen = 1'b1;
      end
      check("runC_re_done_seen", 32'(seen), 32'd1);
    end
    bus.i_dump_ready = 1'b0;
    tick();

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, register data width.
REQ-002 SHALL have parameter NB_ADDR, default 5, register index width (2**NB_ADDR registers).
REQ-003 SHALL have port i_clk input 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst input 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports i_rs_addr, i_rt_addr input NB_ADDR: read-port indices.
REQ-006 SHALL have ports o_rs_data, o_rt_data output NB_DATA: read-port data.
REQ-007 SHALL have port i_write_data input NB_DATA: write-back data.
REQ-008 SHALL have port i_reg2write input NB_ADDR: write-back destination index.
REQ-009 SHALL have port i_regWrite input 1: write enable from write-back stage.
REQ-010 SHALL have port i_dump_start input 1: request a full register dump.
REQ-011 SHALL have ports o_dump_valid output 1, i_dump_ready input 1: dump beat handshake.
REQ-012 SHALL have ports o_dump_data output NB_DATA, o_dump_addr output NB_ADDR: dump beat payload.
REQ-013 SHALL have ports o_dump_busy output 1 (dump in progress), o_dump_done output 1 (one-cycle completion pulse).

Function
REQ-014 SHALL store 2**NB_ADDR registers; register 0 reads 0 always and ignores writes.
REQ-015 SHALL write i_write_data into register i_reg2write on the rising edge when i_regWrite=1 and i_reg2write!=0.
REQ-016 SHALL drive o_rs_data/o_rt_data combinationally from the addressed register (zero latency).
REQ-017 SHALL implement dump FSM states IDLE, SEND, DONE.
REQ-018 IDLE: i_dump_start=1 -> SEND, index=0, o_dump_data loaded with register 0 contents.
REQ-019 SHALL assert o_dump_valid=1 and o_dump_busy=1 throughout SEND; o_dump_addr=current index.
REQ-020 SHALL hold o_dump_data/o_dump_addr stable while o_dump_valid=1 and i_dump_ready=0, even if the register is written meanwhile.
REQ-021 On o_dump_valid&&i_dump_ready with index<max: index+1, o_dump_data reloaded with array contents before that edge's write.
REQ-022 On handshake at index=2**NB_ADDR-1: SEND -> DONE; no index wrap-around beat issued.
REQ-023 DONE SHALL last exactly one cycle with o_dump_done=1, o_dump_busy=0, o_dump_valid=0, then -> IDLE.
REQ-024 SHALL ignore i_dump_start while in SEND or DONE.
REQ-025 Dump SHALL not stall or alter register reads/writes.

Reset
REQ-026 i_rst=1 SHALL immediately clear all registers to 0, FSM to IDLE, index to 0, o_dump_data to 0, o_dump_valid/busy/done to 0.
REQ-027 Reset mid-dump SHALL abort without an o_dump_done pulse.

Configuration
REQ-028 Macro REG_BANK_BYPASS_EN defined: a read whose index equals i_reg2write (nonzero) while i_regWrite=1 SHALL return i_write_data in that cycle.
REQ-029 Macro REG_BANK_BYPASS_EN undefined: such a read SHALL return the pre-write stored value; new value visible next cycle.

Structure
REQ-030 NB_DATA, NB_ADDR defaults and the dump FSM state encoding SHALL live in shared package mips_pkg.
REQ-031 Dump sequencer SHALL be sub-module reg_bank_dump (FSM, index counter, payload register); storage and read ports stay in reg_bank.

Verification
REQ-032 Write 0xDEADBEEF to r5, next cycle rs=5 -> o_rs_data=0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-033 Same cycle write r7=0xA5A5A5A5 and rt=7 -> 0xA5A5A5A5 with REG_BANK_BYPASS_EN, old value (0 after reset) without.
REQ-034 Fill rN=N*3, start dump with i_dump_ready=1 -> 32 beats addr 0..31 data N*3 in consecutive cycles, o_dump_done one cycle after beat 31.
REQ-035 Dump with ready toggled 1/0 and write r3=0xFFFF while beat 3 stalled -> beat 3 data=9 held stable; later r3 reads 0xFFFF.
REQ-036 Assert i_rst during beat 10 -> valid/busy drop immediately, no done pulse, all registers read 0; new i_dump_start restarts at addr 0.
